nr_mem_port_ctrl: RTL and testbench
===================================

Name:
nr_mem_port_ctrl

Overview:
- Initiator/master side of the 8-bit nanoRisk memory port; drives dataMem/instrMem-style memories (write on rising edge with canWrt, read on falling edge with canRd).
- Accepts single-beat write requests and incrementing read bursts from the core over a valid/ready request channel.
- Sequences memory strobes and returns one response per beat over a valid/ready response channel.
- Sits between core load/store logic and the nR memory instances.

Parameters:
AW, 8, address width; addresses wrap modulo 2^AW.
DW, 8, data width.
BOUND_MAX, 8'hEF, highest legal address; used only when NR_MEM_BOUND_CHK_EN is defined.

Ports:
clk  in  1  clock; all state updates on rising edge.
clr  in  1  reset, asynchronous, active-high.
req_valid  in  1  request present.
req_ready  out  1  controller can accept a request.
req_wr  in  1  1=write, 0=read.
req_adr  in  AW  start address.
req_len  in  4  read burst beats minus 1 (0..15 gives 1..16 beats); ignored for writes.
req_wdata  in  DW  write data.
rsp_valid  out  1  response present.
rsp_ready  in  1  core accepts response.
rsp_data  out  DW  read data, or echoed write data on write ack.
rsp_wr  out  1  response is a write ack.
rsp_last  out  1  final beat of the request.
rsp_err  out  1  bound violation (see Optional Feature).
m_adr_in  out  AW  memory write address.
m_in  out  DW  memory write data.
m_can_wrt  out  1  memory write enable.
m_adr_out  out  AW  memory read address.
m_can_rd  out  1  memory read enable.
m_out  in  DW  memory read data; valid by the rising edge that ends a cycle with m_can_rd=1.

Behaviour:
- Reset (async, clr=1): state IDLE; all outputs 0; beat counter 0; current address 0.
- While clr=1, m_can_wrt and m_can_rd are 0 immediately, not at the next edge, and req_ready=0.
- FSM states: IDLE, RD, WR, RESP.
- IDLE: req_ready=1. On a handshake (req_valid&req_ready), latch adr/len/wdata/wr.
  - Go to WR if req_wr=1, else RD.
  - Beat counter loads req_len for reads and 0 for writes.
- RD (exactly 1 cycle):
  - m_can_rd=1, m_adr_out=current address.
  - At the closing edge, capture m_out into rsp_data.
  - rsp_wr=0; rsp_last=(beat counter==0); go to RESP.
- WR (exactly 1 cycle):
  - m_can_wrt=1, m_adr_in=address, m_in=wdata.
  - The memory commits at the closing edge.
  - rsp_data=wdata, rsp_wr=1, rsp_last=1; go to RESP.
- RESP: rsp_valid=1. rsp_data, rsp_wr, rsp_last and rsp_err hold stable until rsp_ready=1.
  - On acceptance: if rsp_last=1, go to IDLE.
  - Otherwise decrement the beat counter, increment the address (wrap 8'hFF to 8'h00), and go to RD.
- m_can_rd/m_can_wrt are high only in RD/WR; never both high; never high in IDLE or RESP.
- Only one request is outstanding; req_ready=0 outside IDLE.
- Latency:
  - Handshake cycle to first rsp_valid is 2 cycles.
  - Steady read burst with rsp_ready held at 1 is 2 cycles per beat.
- Response backpressure: no memory strobe is issued while RESP is waiting.
- Reset mid-burst: remaining beats are dropped and no pending write is committed.
  - A write in WR at the moment clr rises is aborted, because m_can_wrt falls asynchronously.
- Outputs in IDLE: m_adr_in, m_adr_out and m_in hold their last values; only the strobes matter.

Optional Feature:
Macro: NR_MEM_BOUND_CHK_EN.
- Defined: at entry to RD or WR, an address greater than BOUND_MAX suppresses the memory strobe for that beat (the state is still spent for 1 cycle).
  - That beat's response carries rsp_err=1, rsp_data=0 and rsp_last=1.
  - A burst crossing BOUND_MAX terminates at that error beat; the remaining beats are dropped.
  - Earlier in-bound beats respond normally.
- Not defined: no check; rsp_err is tied to 0; the port remains present.

Test Plan:
- Write adr=8'h10, wdata=8'hA5, then read adr=8'h10 len=0 -> m_can_wrt pulses 1 cycle with m_adr_in=8'h10; the read response has rsp_data=8'hA5, rsp_wr=0, rsp_last=1, first rsp_valid 2 cycles after the handshake.
- Preload mem[8'h20..8'h23]=1,2,3,4; read adr=8'h20 len=3, rsp_ready=1 -> 4 responses 1,2,3,4 at 2-cycle spacing; rsp_last only on the 4th; req_ready=0 throughout.
- Read adr=8'hFE len=2 -> addresses 8'hFE, 8'hFF, 8'h00 issued in order; wrap verified.
- Same burst with rsp_ready low for 5 cycles after the first beat -> rsp_data stable, no m_can_rd pulse while stalled, burst resumes correctly.
- Assert clr during the WR cycle of a write of 8'h77 to 8'h30 -> m_can_wrt drops immediately, mem[8'h30] unchanged, all outputs 0, req_ready=1 the cycle after clr falls.
- With NR_MEM_BOUND_CHK_EN, read adr=8'hEE len=3 -> beats 8'hEE and 8'hEF return data; the 3rd beat has rsp_err=1, rsp_data=0, rsp_last=1; no m_can_rd for 8'hF0; FSM returns to IDLE.

Source files
------------

// File: rtl/nr_mem_port_ctrl.sv
// Initiator side of the 8-bit nanoRisk memory port: single-beat writes and incrementing read bursts.
// Optional address bound check is enabled by defining NR_MEM_BOUND_CHK_EN.
module nr_mem_port_ctrl #(
  parameter int              AW        = 8,
  parameter int              DW        = 8,
  parameter logic [AW-1:0]   BOUND_MAX = 8'hEF
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_wr,
  input  logic [AW-1:0] req_adr,
  input  logic [3:0]    req_len,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_wr,
  output logic          rsp_last,
  output logic          rsp_err,
  output logic [AW-1:0] m_adr_in,
  output logic [DW-1:0] m_in,
  output logic          m_can_wrt,
  output logic [AW-1:0] m_adr_out,
  output logic          m_can_rd,
  input  logic [DW-1:0] m_out
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

`ifdef NR_MEM_BOUND_CHK_EN
  localparam bit BOUND_CHK = 1'b1;
`else
  localparam bit BOUND_CHK = 1'b0;
`endif

  state_t        state_reg, state_next;
  logic [3:0]    cnt_reg, cnt_next;
  logic [AW-1:0] adr_reg, adr_next;
  logic [DW-1:0] wdata_reg, wdata_next;
  logic [DW-1:0] rsp_data_reg, rsp_data_next;
  logic          rsp_wr_reg, rsp_wr_next;
  logic          rsp_last_reg, rsp_last_next;
  logic          rsp_err_reg, rsp_err_next;
  logic          oob;

  // Constant 0 when the bound check is compiled out, so rsp_err stays tied low.
  assign oob = BOUND_CHK && (adr_reg > BOUND_MAX);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      adr_reg      <= '0;
      wdata_reg    <= '0;
      rsp_data_reg <= '0;
      rsp_wr_reg   <= 1'b0;
      rsp_last_reg <= 1'b0;
      rsp_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      adr_reg      <= adr_next;
      wdata_reg    <= wdata_next;
      rsp_data_reg <= rsp_data_next;
      rsp_wr_reg   <= rsp_wr_next;
      rsp_last_reg <= rsp_last_next;
      rsp_err_reg  <= rsp_err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    adr_next      = adr_reg;
    wdata_next    = wdata_reg;
    rsp_data_next = rsp_data_reg;
    rsp_wr_next   = rsp_wr_reg;
    rsp_last_next = rsp_last_reg;
    rsp_err_next  = rsp_err_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid && req_ready) begin
          adr_next   = req_adr;
          wdata_next = req_wdata;
          if (req_wr) begin
            state_next = WR;
            cnt_next   = 4'd0;
          end else begin
            state_next = RD;
            cnt_next   = req_len;
          end
        end
      end
      RD: begin
        // An out-of-bound beat ends the burst with an error response.
        rsp_wr_next   = 1'b0;
        rsp_err_next  = oob;
        rsp_data_next = oob ? '0 : m_out;
        rsp_last_next = oob || (cnt_reg == 4'd0);
        state_next    = RESP;
      end
      WR: begin
        rsp_wr_next   = 1'b1;
        rsp_err_next  = oob;
        rsp_data_next = oob ? '0 : wdata_reg;
        rsp_last_next = 1'b1;
        state_next    = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          if (rsp_last_reg) begin
            state_next = IDLE;
          end else begin
            cnt_next   = cnt_reg - 4'd1;
            adr_next   = adr_reg + {{(AW-1){1'b0}}, 1'b1};
            state_next = RD;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Strobes are gated by clr so they drop the instant reset rises.
  assign m_can_rd  = (state_reg == RD) && !oob && !clr;
  assign m_can_wrt = (state_reg == WR) && !oob && !clr;
  assign req_ready = (state_reg == IDLE) && !clr;
  assign rsp_valid = (state_reg == RESP);
  assign rsp_data  = rsp_data_reg;
  assign rsp_wr    = rsp_wr_reg;
  assign rsp_last  = rsp_last_reg;
  assign rsp_err   = rsp_err_reg;
  assign m_adr_in  = adr_reg;
  assign m_adr_out = adr_reg;
  assign m_in      = wdata_reg;

endmodule

// File: tb/tb_nr_mem_port_ctrl.sv
// Bench for nr_mem_port_ctrl: memory model plus a transaction-level reference of the expected beats.
// Bound-check scenario runs only when NR_MEM_BOUND_CHK_EN is defined.
module tb_nr_mem_port_ctrl;

  localparam logic [7:0] BOUND = 8'hEF;
`ifdef NR_MEM_BOUND_CHK_EN
  localparam bit BCHK = 1'b1;
`else
  localparam bit BCHK = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    logic       wr;
    logic       last;
    logic       err;
  } beat_t;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       req_valid = 1'b0, req_wr = 1'b0;
  logic [7:0] req_adr = 8'h00, req_wdata = 8'h00;
  logic [3:0] req_len = 4'h0;
  logic       rsp_ready = 1'b0;
  logic       req_ready, rsp_valid, rsp_wr, rsp_last, rsp_err;
  logic [7:0] rsp_data, m_adr_in, m_in, m_adr_out;
  logic       m_can_wrt, m_can_rd;
  logic [7:0] m_out = 8'h00;

  logic       pl_en = 1'b0;
  logic [7:0] pl_adr = 8'h00, pl_dat = 8'h00;
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;

  nr_mem_port_ctrl dut (
    .clk(clk), .clr(clr),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_adr(req_adr), .req_len(req_len), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_wr(rsp_wr), .rsp_last(rsp_last), .rsp_err(rsp_err),
    .m_adr_in(m_adr_in), .m_in(m_in), .m_can_wrt(m_can_wrt),
    .m_adr_out(m_adr_out), .m_can_rd(m_can_rd), .m_out(m_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // nR-style memory: write on rising edge, read on falling edge.
  always @(posedge clk) begin
    if (pl_en) mem[pl_adr] <= pl_dat;
    else if (m_can_wrt) mem[m_adr_in] <= m_in;
  end
  always @(negedge clk) if (m_can_rd) m_out <= mem[m_adr_out];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_adr = a; pl_dat = d; ref_mem[a] = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) begin
      @(posedge clk); #1;
      pl_en = 1'b1; pl_adr = 8'(i); pl_dat = 8'($urandom); ref_mem[i] = pl_dat;
    end
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Issue one request, drain its responses and check them against the reference beats.
  task automatic run_req(input bit wr, input logic [7:0] adr, input logic [3:0] len,
                         input logic [7:0] wd, input int stall_pct, input int hold_first,
                         input bit chk_spacing);
    beat_t      exp_q[$];
    beat_t      b, prev;
    logic [7:0] exp_rd[$], exp_wa[$], exp_wd[$];
    logic [7:0] rd_q[$], wa_q[$], wd_q[$];
    logic [7:0] a;
    bit         oob, hs, first, holding;
    int         h, last_acc, got, guard, stall_left;
    hs = 0; first = 0; holding = 0; h = 0; last_acc = 0; got = 0; guard = 0; stall_left = 0;
    prev.data = 8'h00; prev.wr = 1'b0; prev.last = 1'b0; prev.err = 1'b0;

    if (wr) begin
      oob = BCHK && (adr > BOUND);
      b.data = oob ? 8'h00 : wd; b.wr = 1'b1; b.last = 1'b1; b.err = oob;
      exp_q.push_back(b);
      if (!oob) begin
        exp_wa.push_back(adr); exp_wd.push_back(wd); ref_mem[adr] = wd;
      end
    end else begin
      for (int i = 0; i <= int'(len); i++) begin
        a = adr + 8'(i);
        if (BCHK && (a > BOUND)) begin
          b.data = 8'h00; b.wr = 1'b0; b.last = 1'b1; b.err = 1'b1;
          exp_q.push_back(b);
          break;
        end
        b.data = ref_mem[a]; b.wr = 1'b0; b.last = (i == int'(len)); b.err = 1'b0;
        exp_q.push_back(b);
        exp_rd.push_back(a);
      end
    end

    @(posedge clk); #1;
    req_valid = 1'b1; req_wr = wr; req_adr = adr; req_len = len; req_wdata = wd;
    rsp_ready = ($urandom_range(99) >= stall_pct);
    while (got < exp_q.size() && guard < 200) begin
      @(negedge clk);
      guard++;
      if (hs) begin
        n_cmp++;
        if (req_ready !== 1'b0) begin
          n_fail++; $display("FAIL req_ready_busy: got %b want 0 (cyc %0d)", req_ready, cyc);
        end
      end
      if (!hs && req_valid && req_ready) begin hs = 1; h = cyc; end
      if (m_can_rd === 1'b1) rd_q.push_back(m_adr_out);
      if (m_can_wrt === 1'b1) begin wa_q.push_back(m_adr_in); wd_q.push_back(m_in); end
      n_cmp++;
      if ((m_can_rd & m_can_wrt) !== 1'b0) begin
        n_fail++; $display("FAIL both_strobes: rd=%b wrt=%b want not both", m_can_rd, m_can_wrt);
      end
      if (rsp_valid === 1'b1) begin
        if (!first) begin
          first = 1; n_cmp++;
          if (cyc - h != 2) begin
            n_fail++; $display("FAIL first_latency: got %0d want 2", cyc - h);
          end
        end
        if (holding) begin
          n_cmp++;
          if ({rsp_data, rsp_wr, rsp_last, rsp_err} !== {prev.data, prev.wr, prev.last, prev.err}) begin
            n_fail++;
            $display("FAIL rsp_stable: got %02h/%b/%b/%b want %02h/%b/%b/%b", rsp_data, rsp_wr,
                     rsp_last, rsp_err, prev.data, prev.wr, prev.last, prev.err);
          end
        end
        if (rsp_ready) begin
          b = exp_q[got];
          n_cmp++;
          if ({rsp_data, rsp_wr, rsp_last, rsp_err} !== {b.data, b.wr, b.last, b.err}) begin
            n_fail++;
            $display("FAIL beat%0d: got data=%02h wr=%b last=%b err=%b want data=%02h wr=%b last=%b err=%b",
                     got, rsp_data, rsp_wr, rsp_last, rsp_err, b.data, b.wr, b.last, b.err);
          end
          if (chk_spacing && got > 0) begin
            n_cmp++;
            if (cyc - last_acc != 2) begin
              n_fail++; $display("FAIL beat_spacing: got %0d want 2", cyc - last_acc);
            end
          end
          last_acc = cyc; got++; holding = 0;
          if (got == 1) stall_left = hold_first;
        end else begin
          holding = 1;
          prev.data = rsp_data; prev.wr = rsp_wr; prev.last = rsp_last; prev.err = rsp_err;
        end
      end
      @(posedge clk); #1;
      if (hs) req_valid = 1'b0;
      if (stall_left > 0) begin
        rsp_ready = 1'b0; stall_left--;
      end else begin
        rsp_ready = ($urandom_range(99) >= stall_pct);
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    n_cmp++;
    if (got < exp_q.size()) begin
      n_fail++; $display("FAIL timeout: got %0d beats want %0d", got, exp_q.size());
    end

    @(negedge clk);
    if (m_can_rd === 1'b1) rd_q.push_back(m_adr_out);
    if (m_can_wrt === 1'b1) begin wa_q.push_back(m_adr_in); wd_q.push_back(m_in); end
    n_cmp++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL idle_return: req_ready=%b rsp_valid=%b want 1/0", req_ready, rsp_valid);
    end
    n_cmp++;
    if (rd_q.size() != exp_rd.size() || wa_q.size() != exp_wa.size()) begin
      n_fail++;
      $display("FAIL strobe_count: rd %0d want %0d, wrt %0d want %0d", rd_q.size(), exp_rd.size(),
               wa_q.size(), exp_wa.size());
    end else begin
      foreach (exp_rd[i]) begin
        n_cmp++;
        if (rd_q[i] !== exp_rd[i]) begin
          n_fail++; $display("FAIL rd_adr%0d: got %02h want %02h", i, rd_q[i], exp_rd[i]);
        end
      end
      foreach (exp_wa[i]) begin
        n_cmp++;
        if (wa_q[i] !== exp_wa[i] || wd_q[i] !== exp_wd[i]) begin
          n_fail++;
          $display("FAIL wr_strobe%0d: got %02h<=%02h want %02h<=%02h", i, wa_q[i], wd_q[i],
                   exp_wa[i], exp_wd[i]);
        end
      end
    end
    $display("txn wr=%0d adr=%02h len=%0d wdata=%02h beats=%0d", wr, adr, len, wd, got);
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_data, rsp_wr, rsp_last, rsp_err, m_adr_in, m_in, m_can_wrt,
         m_adr_out, m_can_rd} !== 39'd0) begin
      n_fail++; $display("FAIL reset_outputs: some output nonzero during clr (req_ready=%b rsp_valid=%b)",
                         req_ready, rsp_valid);
    end
    repeat (3) @(posedge clk);
    @(negedge clk); clr = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release: req_ready=%b want 1", req_ready);
    end
    $display("txn reset released");
  endtask

  task automatic test_write_read();
    run_req(1'b1, 8'h10, 4'd0, 8'hA5, 0, 0, 1'b0);
    run_req(1'b0, 8'h10, 4'd0, 8'h00, 0, 0, 1'b0);
  endtask

  task automatic test_burst();
    for (int i = 0; i < 4; i++) preload(8'h20 + 8'(i), 8'(i + 1));
    run_req(1'b0, 8'h20, 4'd3, 8'h00, 0, 0, 1'b1);
  endtask

  task automatic test_wrap();
    run_req(1'b0, 8'hFE, 4'd2, 8'h00, 0, 0, 1'b1);
  endtask

  task automatic test_back_pressure();
    run_req(1'b0, 8'hFE, 4'd2, 8'h00, 0, 5, 1'b0);
  endtask

  task automatic test_reset_mid_write();
    logic [7:0] old;
    old = ref_mem[8'h30];
    @(posedge clk); #1;
    req_valid = 1'b1; req_wr = 1'b1; req_adr = 8'h30; req_wdata = 8'h77; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #2;
    n_cmp++;
    if (m_can_wrt !== 1'b1 || m_adr_in !== 8'h30) begin
      n_fail++; $display("FAIL wr_cycle: m_can_wrt=%b m_adr_in=%02h want 1/30", m_can_wrt, m_adr_in);
    end
    clr = 1'b1;
    #1;
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_data, rsp_wr, rsp_last, rsp_err, m_adr_in, m_in, m_can_wrt,
         m_adr_out, m_can_rd} !== 39'd0) begin
      n_fail++; $display("FAIL clr_async: m_can_wrt=%b m_adr_in=%02h m_in=%02h want all 0",
                         m_can_wrt, m_adr_in, m_in);
    end
    @(posedge clk);
    @(negedge clk); clr = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL clr_release: req_ready=%b rsp_valid=%b want 1/0", req_ready, rsp_valid);
    end
    n_cmp++;
    if (mem[8'h30] !== old) begin
      n_fail++; $display("FAIL aborted_write: mem[30]=%02h want %02h", mem[8'h30], old);
    end
    $display("txn write 30<=77 aborted by clr");
  endtask

`ifdef NR_MEM_BOUND_CHK_EN
  task automatic test_bound();
    run_req(1'b0, 8'hEE, 4'd3, 8'h00, 0, 0, 1'b1);
    run_req(1'b1, 8'hF5, 4'd0, 8'h3C, 0, 0, 1'b0);
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      run_req(1'($urandom_range(1)), 8'($urandom), 4'($urandom), 8'($urandom), 30, 0, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    fill_mem();
    test_write_read();
    test_burst();
    test_wrap();
    test_back_pressure();
    test_reset_mid_write();
`ifdef NR_MEM_BOUND_CHK_EN
    test_bound();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
